iterative_muldiv_unit: RTL and testbench

//   Multi-cycle RV32M execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.

---
 rtl/iterative_muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_iterative_muldiv_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit (radix-2).
// One shift-add (multiply) or one restoring-subtract (divide) per cycle, so every op has the
// same fixed latency. Operands are reduced to magnitudes at accept time. All iteration is
// unsigned. Sign correction happens once, in the FIX cycle.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   start      request, accepted only in IDLE and only when flush=0
//   flush      synchronous abort of an in-flight op; in IDLE it blocks start
//   op         funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   operand_a  rs1 (multiplicand / dividend)
//   operand_b  rs2 (multiplier / divisor)
//   busy       state != IDLE
//   done       registered one-cycle pulse, result valid
//   result     registered result, held until the next done
module iterative_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // hi/lo form one 2*WIDTH shift register.
  // mul: {product high, multiplier shifting out / product low}
  // div: {partial remainder, dividend shifting out / quotient shifting in}
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;     // multiplicand magnitude or divisor magnitude
  logic             neg_q, neg_d;     // negate the selected result in FIX
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Accept-time decode.
  logic             is_div;
  logic             a_signed, b_signed, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_new;

  // Iteration datapath.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  // Sign-correction datapath.
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_val;

  always_comb begin
    is_div   = op[2];
    a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg    = a_signed && operand_a[WIDTH-1];
    b_neg    = b_signed && operand_b[WIDTH-1];
    b_zero   = (operand_b == '0);
    mag_a    = a_neg ? -operand_a : operand_a;
    mag_b    = b_neg ? -operand_b : operand_b;
    case (op)
      3'd1, 3'd2: neg_new = a_neg ^ b_neg;
      // Divide by zero returns all ones unsigned, so the quotient sign must not flip it.
      3'd4:       neg_new = (a_neg ^ b_neg) && !b_zero;
      3'd6:       neg_new = a_neg;  // remainder takes the dividend's sign
      default:    neg_new = 1'b0;
    endcase
  end

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
  end

  always_comb begin
    prod_raw = {hi_q, lo_q};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_q ? -hi_q : hi_q;
    case (op_q)
      3'd0:       fix_val = prod_fix[WIDTH-1:0];
      3'd1, 3'd2,
      3'd3:       fix_val = prod_fix[2*WIDTH-1:WIDTH];
      3'd4, 3'd5: fix_val = quo_fix;
      default:    fix_val = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d    = op;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = is_div ? mag_a : mag_b;
          opb_d   = is_div ? mag_b : mag_a;
          neg_d   = neg_new;
          state_d = StRun;
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          if (op_q[2]) begin
            // Restoring step: keep the difference only when it did not borrow.
            if (!div_diff[WIDTH]) begin
              hi_d = div_diff[WIDTH-1:0];
              lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_d = div_shift[WIDTH-1:0];
              lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          result_d = fix_val;
          done_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Self-checking bench for iterative_muldiv_unit.
// Directed cases cover the known corner values. Random ops are compared against a
// 64-bit arithmetic reference model.
module tb_iterative_muldiv_unit;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          flush;
  logic [2:0]    op;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;

  int checks      = 0;
  int failures    = 0;
  int done_pulses = 0;

  iterative_muldiv_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .flush     (flush),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_pulses++;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // RV32M semantics in plain 64-bit arithmetic.
  function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint          sa, sb, ubs;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = 64'(a);
    ub  = 64'(b);
    ubs = longint'(ub);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model = '0;
    case (f)
      3'd0: begin p = ua * ub;  model = p[31:0];  end
      3'd1: begin p = sa * sb;  model = p[63:32]; end
      3'd2: begin p = sa * ubs; model = p[63:32]; end
      3'd3: begin p = ua * ub;  model = p[63:32]; end
      3'd4: begin
        if (b == 0)   model = '1;
        else if (ovf) model = a;
        else begin p = sa / sb; model = p[31:0]; end
      end
      3'd5: model = (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0)   model = a;
        else if (ovf) model = '0;
        else begin p = sa % sb; model = p[31:0]; end
      end
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Call at a negedge; returns just after the accepting posedge with garbage on the inputs.
  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    op = f; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    op = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
  endtask

  // Returns at the negedge where done is seen (or after the cycle budget runs out).
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    for (int n = 1; n <= W + 10; n++) begin
      @(negedge clock);
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_check(input string tag, input logic [2:0] f, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp);
    int lat, bcnt;
    issue(f, a, b);
    wait_done(lat, bcnt);
    check({tag, " latency"}, W'(lat), W'(W + 2));
    check({tag, " busy"}, W'(bcnt), W'(W + 1));
    check({tag, " result"}, result, exp);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       rnd_operand = '0;
      1:       rnd_operand = 32'd1;
      2:       rnd_operand = '1;
      3:       rnd_operand = 32'h8000_0000;
      4:       rnd_operand = W'($urandom_range(0, 20));
      default: rnd_operand = $urandom;
    endcase
  endfunction

  initial begin
    int p0;
    logic [2:0]   f;
    logic [W-1:0] a, b;

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clock);
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    check("reset result", result, '0);
    reset = 1'b0;
    @(negedge clock);

    // Directed corners; consecutive calls are back-to-back (start in the done cycle).
    run_check("mul 7*6", 3'd0, 32'd7, 32'd6, 32'h0000_002A);
    run_check("mulh -1*-1", 3'd1, '1, '1, 32'h0000_0000);
    run_check("mulhu", 3'd3, '1, '1, 32'hFFFF_FFFE);
    run_check("mulhsu", 3'd2, '1, '1, 32'hFFFF_FFFF);
    run_check("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_check("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_check("divu 100/7", 3'd5, 32'd100, 32'd7, 32'd14);
    run_check("remu 100/7", 3'd7, 32'd100, 32'd7, 32'd2);
    run_check("div 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_check("remu 5/0", 3'd7, 32'd5, 32'd0, 32'd5);
    run_check("div -7/0", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    run_check("rem -7/0", 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    run_check("div ovf", 3'd4, 32'h8000_0000, '1, 32'h8000_0000);
    run_check("rem ovf", 3'd6, 32'h8000_0000, '1, 32'h0000_0000);
    run_check("mul 3*3 b2b", 3'd0, 32'd3, 32'd3, 32'd9);

    @(negedge clock);
    check("done one pulse", W'(done), '0);

    // Start pulsed mid-RUN is dropped.
    issue(3'd5, 32'd100, 32'd7);
    p0 = done_pulses;
    repeat (10) @(negedge clock);
    op = 3'd0; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (W + 10) @(negedge clock);
    #1;
    check("midrun start dones", W'(done_pulses - p0), W'(1));
    check("midrun start result", result, 32'd14);

    // Asynchronous reset mid-RUN.
    @(negedge clock);
    issue(3'd0, 32'd7, 32'd6);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    check("async rst busy", W'(busy), '0);
    check("async rst done", W'(done), '0);
    check("async rst result", result, '0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Flush in RUN: no done, result keeps its prior value.
    run_check("divu pre-flush", 3'd5, 32'd100, 32'd7, 32'd14);
    issue(3'd3, '1, '1);
    repeat (5) @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    check("flush run busy", W'(busy), '0);
    p0 = done_pulses;
    repeat (W + 5) @(negedge clock);
    #1;
    check("flush run dones", W'(done_pulses - p0), '0);
    check("flush run result", result, 32'd14);

    // Flush in FIX.
    @(negedge clock);
    issue(3'd3, '1, '1);
    p0 = done_pulses;
    repeat (W + 1) @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    check("flush fix busy", W'(busy), '0);
    repeat (5) @(negedge clock);
    #1;
    check("flush fix dones", W'(done_pulses - p0), '0);
    check("flush fix result", result, 32'd14);

    // Flush in IDLE blocks start.
    @(negedge clock);
    op = 3'd0; operand_a = 32'd2; operand_b = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0; flush = 1'b0;
    check("flush idle busy", W'(busy), '0);

    // Random ops against the model.
    @(negedge clock);
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      a = rnd_operand();
      b = rnd_operand();
      run_check("rand", f, a, b, model(f, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
